regfile_hilo: RTL and testbench
===============================

# regfile_hilo

- Architectural state block at the receiving end of the writeback bus: 32×32 general-purpose register file plus HI/LO registers.
- Captures the register, HI and LO writes carried on the writeback bus at each rising clock edge.
- Serves two combinational GPR read ports and HI/LO read ports to the decode stage, with same-cycle write-through bypass.
- Register `$0` always reads zero.

## Interface
Parameters:
- `WB_TO_RF_WD`, default 104: width of the writeback bus.
- `BYPASS`, default 1:
  - 1: a read of a location being written in the current cycle returns the incoming write data.
  - 0: the read returns the stored value.

Ports:
- `clk` input 1: clock, all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `wb_to_rf_bus` input `WB_TO_RF_WD`: writeback bus, fields listed under Operation.
- `raddr1` input 5: GPR read address, port 1.
- `raddr2` input 5: GPR read address, port 2.
- `rdata1` output 32: GPR read data, port 1.
- `rdata2` output 32: GPR read data, port 2.
- `hi_rdata` output 32: HI read data.
- `lo_rdata` output 32: LO read data.

## Operation
Bus field decode:
- [103] `hi_we`
- [102:71] `hi_wdata`
- [70] `lo_we`
- [69:38] `lo_wdata`
- [37] `rf_we`
- [36:32] `rf_waddr`
- [31:0] `rf_wdata`

An all-zero bus (the stall/bubble encoding) performs no write.

GPR write:
- On the rising edge with `rst`=0, `rf_we`=1 and `rf_waddr`≠0: `regs[rf_waddr]` ← `rf_wdata`.
- Writes to address 0 are discarded.

HI/LO write:
- On the rising edge with `rst`=0: HI ← `hi_wdata` if `hi_we`; LO ← `lo_wdata` if `lo_we`.
- HI and LO write independently.
- Both may be written in the same cycle as a GPR write.

GPR read, per port, combinational:
- `raddr`=0 → 0, regardless of the bus.
- Else, if `BYPASS`=1, `rf_we`=1 and `rf_waddr`=`raddr` → `rf_wdata`.
- Else → `regs[raddr]`.
- Both ports may read the same address; both may hit the bypass.

HI/LO read:
- If `BYPASS`=1 and `hi_we`=1 → `hi_wdata`; else the stored HI.
- LO follows the same rule with `lo_we`/`lo_wdata`.

Reset:
- On the rising edge with `rst`=1, all 32 GPRs, HI and LO are cleared to 0.
- A write presented on the same edge is ignored.
- With `rst` held high, reads still apply the bypass rules against the bus. Upstream drives the bus to zero during reset, so all outputs read 0.

Width rules:
- No arithmetic; data passes through unmodified at 32 bits.
- Bits above [103], if `WB_TO_RF_WD`>104, are ignored.

## Timing
- Write latency: data on the bus in cycle N is stored at the edge ending cycle N.
  - Visible from storage in cycle N+1.
  - Visible via bypass in cycle N when `BYPASS`=1.
- Read latency: 0 cycles (combinational from `raddr*`, storage, and bus).
- Output values after reset: `rdata1`, `rdata2`, `hi_rdata`, `lo_rdata` all 0 until the first write.
- Back-to-back writes to the same register in consecutive cycles: the last one wins. Each intermediate value is visible via bypass in its own cycle.
- No stall/flush inputs. Writeback freezing is expressed by a zero bus.

## Test plan
- Reset then read:
  - Stimulus: assert `rst` for 2 cycles; release; `raddr1`=5, `raddr2`=31, bus=0.
  - Required: `rdata1`=`rdata2`=`hi_rdata`=`lo_rdata`=0.
- Write and readback:
  - Stimulus: bus `rf_we`=1, `rf_waddr`=8, `rf_wdata`=0xDEADBEEF for one cycle; then bus=0 and `raddr1`=8.
  - Required: `rdata1`=0xDEADBEEF in the next cycle and every cycle thereafter until overwritten.
- `$0` protection:
  - Stimulus: write 0x12345678 to address 0; then `raddr1`=`raddr2`=0.
  - Required: both read 0, both in the write cycle and after it.
- Bypass:
  - Stimulus: `BYPASS`=1; stored r3=0x11; same cycle, bus writes r3=0x22 with `raddr1`=`raddr2`=3.
  - Required: both ports read 0x22 in that cycle.
  - Same stimulus with `BYPASS`=0: both ports read 0x11 in that cycle, 0x22 in the next.
- HI/LO independence:
  - Stimulus: bus `hi_we`=1, `hi_wdata`=0xAAAA0000, `lo_we`=0, `lo_wdata`=0xFFFFFFFF, plus `rf_we`=1 writing r9=0x7.
  - Required: `hi_rdata`=0xAAAA0000; `lo_rdata` unchanged (0); r9=0x7.
  - Then set only `lo_we`=1 with `lo_wdata`=0x5: `lo_rdata`=0x5, `hi_rdata` stays 0xAAAA0000.
- Reset mid-operation:
  - Stimulus: r4=0x99 stored; assert `rst` in the same cycle as a bus write r4=0x55, `hi_we`=1 with `hi_wdata`=0x1; release `rst` with bus=0.
  - Required: r4 reads 0 and `hi_rdata`=0 after release.

Source files
------------

// File: rtl/regfile_hilo.sv
`default_nettype none
// regfile_hilo: 32x32 GPR file plus HI/LO, written from the writeback bus, read combinationally with optional write-through bypass.
// Rev 1.0
module regfile_hilo #(
  parameter int WB_TO_RF_WD = 104,
  parameter int BYPASS      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
  input  logic [4:0]             raddr1,
  input  logic [4:0]             raddr2,
  output logic [31:0]            rdata1,
  output logic [31:0]            rdata2,
  output logic [31:0]            hi_rdata,
  output logic [31:0]            lo_rdata
);

  localparam logic BYPASS_EN = (BYPASS != 0);

  logic        hi_we;
  logic [31:0] hi_wdata;
  logic        lo_we;
  logic [31:0] lo_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [31:0] regs [32];
  logic [31:0] hi;
  logic [31:0] lo;

  assign hi_we    = wb_to_rf_bus[103];
  assign hi_wdata = wb_to_rf_bus[102:71];
  assign lo_we    = wb_to_rf_bus[70];
  assign lo_wdata = wb_to_rf_bus[69:38];
  assign rf_we    = wb_to_rf_bus[37];
  assign rf_waddr = wb_to_rf_bus[36:32];
  assign rf_wdata = wb_to_rf_bus[31:0];

  // Bits above 103 on a wider bus carry nothing for this block.
  generate
    if (WB_TO_RF_WD > 104) begin : g_wide_bus
      logic unused_upper;
      assign unused_upper = ^wb_to_rf_bus[WB_TO_RF_WD-1:104];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      hi <= '0;
      lo <= '0;
    end else begin
      if (rf_we && (rf_waddr != 5'd0)) begin
        regs[rf_waddr] <= rf_wdata;
      end
      if (hi_we) begin
        hi <= hi_wdata;
      end
      if (lo_we) begin
        lo <= lo_wdata;
      end
    end
  end

  // $0 is forced to zero at the read side, independent of storage and bus.
  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 :
                  (BYPASS_EN && rf_we && (rf_waddr == raddr1)) ? rf_wdata : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 :
                  (BYPASS_EN && rf_we && (rf_waddr == raddr2)) ? rf_wdata : regs[raddr2];

  assign hi_rdata = (BYPASS_EN && hi_we) ? hi_wdata : hi;
  assign lo_rdata = (BYPASS_EN && lo_we) ? lo_wdata : lo;

endmodule
`default_nettype wire

// File: tb/tb_regfile_hilo.sv
`default_nettype none
// tb_regfile_hilo: scoreboard bench running a bypassing and a non-bypassing instance side by side.
// Rev 1.0
module tb_regfile_hilo;

  typedef struct {
    string       tag;
    logic [31:0] r1_b, r2_b, hi_b, lo_b;
    logic [31:0] r1_n, r2_n, hi_n, lo_n;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [103:0]  bus;
  logic [4:0]    ra1, ra2;
  logic [31:0]   rd1_b, rd2_b, hi_b, lo_b;
  logic [31:0]   rd1_n, rd2_n, hi_n, lo_n;

  logic [31:0]   m_regs [32];
  logic [31:0]   m_hi, m_lo;
  exp_t          sb [$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  regfile_hilo #(.WB_TO_RF_WD(104), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .wb_to_rf_bus(bus), .raddr1(ra1), .raddr2(ra2),
    .rdata1(rd1_b), .rdata2(rd2_b), .hi_rdata(hi_b), .lo_rdata(lo_b)
  );

  regfile_hilo #(.WB_TO_RF_WD(104), .BYPASS(0)) dut_nob (
    .clk(clk), .rst(rst), .wb_to_rf_bus(bus), .raddr1(ra1), .raddr2(ra2),
    .rdata1(rd1_n), .rdata2(rd2_n), .hi_rdata(hi_n), .lo_rdata(lo_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [103:0] mk_bus(input logic hwe, input logic [31:0] hwd,
                                          input logic lwe, input logic [31:0] lwd,
                                          input logic rwe, input logic [4:0] wa,
                                          input logic [31:0] wd);
    return {hwe, hwd, lwe, lwd, rwe, wa, wd};
  endfunction

  function automatic logic [31:0] model_gpr(input logic [4:0] a, input logic [103:0] b,
                                            input logic byp);
    if (a == 5'd0) return 32'd0;
    if (byp && b[37] && (b[36:32] == a)) return b[31:0];
    return m_regs[a];
  endfunction

  // One cycle: drive, predict, compare mid-cycle, then advance the model at the edge.
  task automatic step(input string tag, input logic r, input logic [103:0] b,
                      input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    exp_t got;
    rst = r;
    bus = b;
    ra1 = a1;
    ra2 = a2;
    e.tag  = tag;
    e.r1_b = model_gpr(a1, b, 1'b1);
    e.r2_b = model_gpr(a2, b, 1'b1);
    e.hi_b = b[103] ? b[102:71] : m_hi;
    e.lo_b = b[70]  ? b[69:38]  : m_lo;
    e.r1_n = model_gpr(a1, b, 1'b0);
    e.r2_n = model_gpr(a2, b, 1'b0);
    e.hi_n = m_hi;
    e.lo_n = m_lo;
    sb.push_back(e);
    #3;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      chk({got.tag, ".rd1_byp"}, rd1_b, got.r1_b);
      chk({got.tag, ".rd2_byp"}, rd2_b, got.r2_b);
      chk({got.tag, ".hi_byp"},  hi_b,  got.hi_b);
      chk({got.tag, ".lo_byp"},  lo_b,  got.lo_b);
      chk({got.tag, ".rd1_nob"}, rd1_n, got.r1_n);
      chk({got.tag, ".rd2_nob"}, rd2_n, got.r2_n);
      chk({got.tag, ".hi_nob"},  hi_n,  got.hi_n);
      chk({got.tag, ".lo_nob"},  lo_n,  got.lo_n);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_hi = 32'd0;
      m_lo = 32'd0;
    end else begin
      if (b[37] && (b[36:32] != 5'd0)) m_regs[b[36:32]] = b[31:0];
      if (b[103]) m_hi = b[102:71];
      if (b[70])  m_lo = b[69:38];
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    rst = 1'b1;
    bus = '0;
    ra1 = 5'd0;
    ra2 = 5'd0;
    @(posedge clk);
    #1;

    step("reset_a", 1'b1, '0, 5'd5, 5'd31);
    step("reset_b", 1'b1, '0, 5'd5, 5'd31);
    step("post_rst", 1'b0, '0, 5'd5, 5'd31);

    step("wr_r8", 1'b0, mk_bus(0, 0, 0, 0, 1, 5'd8, 32'hDEADBEEF), 5'd8, 5'd8);
    step("rd_r8_a", 1'b0, '0, 5'd8, 5'd1);
    step("rd_r8_b", 1'b0, '0, 5'd8, 5'd8);

    step("wr_r0", 1'b0, mk_bus(0, 0, 0, 0, 1, 5'd0, 32'h12345678), 5'd0, 5'd0);
    step("rd_r0", 1'b0, '0, 5'd0, 5'd0);

    step("wr_r3_11", 1'b0, mk_bus(0, 0, 0, 0, 1, 5'd3, 32'h11), 5'd3, 5'd8);
    step("byp_r3_22", 1'b0, mk_bus(0, 0, 0, 0, 1, 5'd3, 32'h22), 5'd3, 5'd3);
    step("rd_r3", 1'b0, '0, 5'd3, 5'd3);

    step("hi_r9", 1'b0, mk_bus(1, 32'hAAAA0000, 0, 32'hFFFFFFFF, 1, 5'd9, 32'h7), 5'd9, 5'd3);
    step("rd_hi_r9", 1'b0, '0, 5'd9, 5'd9);
    step("lo_only", 1'b0, mk_bus(0, 32'h0, 1, 32'h5, 0, 5'd0, 32'h0), 5'd9, 5'd0);
    step("rd_hilo", 1'b0, '0, 5'd9, 5'd8);

    step("b2b_1", 1'b0, mk_bus(0, 0, 0, 0, 1, 5'd10, 32'h1), 5'd10, 5'd10);
    step("b2b_2", 1'b0, mk_bus(0, 0, 0, 0, 1, 5'd10, 32'h2), 5'd10, 5'd10);
    step("b2b_3", 1'b0, mk_bus(0, 0, 0, 0, 1, 5'd10, 32'h3), 5'd10, 5'd10);
    step("b2b_rd", 1'b0, '0, 5'd10, 5'd10);

    step("wr_r4_99", 1'b0, mk_bus(0, 0, 0, 0, 1, 5'd4, 32'h99), 5'd4, 5'd4);
    step("rst_mid", 1'b1, mk_bus(1, 32'h1, 0, 0, 1, 5'd4, 32'h55), 5'd4, 5'd4);
    step("post_mid", 1'b0, '0, 5'd4, 5'd9);

    for (int n = 0; n < 60; n++) begin
      step("rand", 1'b0,
           mk_bus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    for (int a = 0; a < 32; a++) begin
      step("sweep", 1'b0, '0, 5'(a), 5'(31 - a));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
